// File: rtl/video_stream_pkg.sv
// Shared definitions for the video stream blocks (pattern source, capture, line buffer).
package video_stream_pkg;

  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_HRAMP = 2'd1;
  localparam logic [1:0] MODE_VRAMP = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DELAY  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VBLANK = 3'd4
  } vps_state_e;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/video_pattern_pixel.sv
// Combinational test-pattern generator: (x, y, mode, const_val) -> packed multi-channel pixel.
module video_pattern_pixel
  import video_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int XW         = 12,
  parameter int YW         = 11
) (
  input  logic [XW-1:0]                  x_i,
  input  logic [YW-1:0]                  y_i,
  input  logic [1:0]                     mode_i,
  input  logic [DATA_WIDTH-1:0]          const_val_i,
  output logic [DATA_WIDTH*CHANNELS-1:0] pixel_o
);

  // Coordinates widened so ramp bits and the checker bit (bit 3) always exist.
  localparam int XE = max_int(max_int(XW, DATA_WIDTH), 4);
  localparam int YE = max_int(max_int(YW, DATA_WIDTH), 4);

  logic [XE-1:0]         x_e;
  logic [YE-1:0]         y_e;
  logic [DATA_WIDTH-1:0] base;
  logic                  unused_hi;

  assign x_e       = XE'(x_i);
  assign y_e       = YE'(y_i);
  assign unused_hi = ^{x_e, y_e};

  // Channel-0 pattern value; ramps wrap modulo 2^DATA_WIDTH.
  always_comb begin
    base = '0;
    case (mode_i)
      MODE_CONST: base = const_val_i;
      MODE_HRAMP: base = x_e[DATA_WIDTH-1:0];
      MODE_VRAMP: base = y_e[DATA_WIDTH-1:0];
      default:    base = (x_e[3] ^ y_e[3]) ? '1 : '0;
    endcase
  end

  // Channel c carries base + c, packed LSB-first.
  always_comb begin
    pixel_o = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pixel_o[c*DATA_WIDTH +: DATA_WIDTH] = base + DATA_WIDTH'(c);
    end
  end

endmodule

// File: rtl/video_pattern_src.sv
// AXI4-Stream video pattern source: frame/line FSM, x/y counters, blanking timers and a
// registered AXI output stage that holds steady under backpressure.
// The start delay always passes through DELAY so the first beat lands START_DELAY+1 cycles
// after start is sampled, including START_DELAY=0.
module video_pattern_src
  import video_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNELS    = 1,
  parameter int IMG_WIDTH   = 2560,
  parameter int IMG_HEIGHT  = 1440,
  parameter int HBLANK      = 16,
  parameter int VBLANK      = 4,
  parameter int START_DELAY = 16
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [1:0]                     mode,
  input  logic [DATA_WIDTH-1:0]          const_val,
  output logic [DATA_WIDTH*CHANNELS-1:0] m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tuser,
  output logic                           m_axis_tlast,
  output logic                           busy,
  output logic                           frame_done,
  output logic [15:0]                    frame_cnt
);

  localparam int XW      = safe_clog2(IMG_WIDTH);
  localparam int YW      = safe_clog2(IMG_HEIGHT);
  localparam int PW      = DATA_WIDTH * CHANNELS;
  localparam int VB_CYC  = VBLANK * (IMG_WIDTH + HBLANK);
  localparam int CNT_MAX = max_int(max_int(START_DELAY, HBLANK), VB_CYC);
  localparam int CW      = safe_clog2(CNT_MAX + 1);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] SD_END = CW'(START_DELAY);
  localparam logic [CW-1:0] HB_END = CW'(HBLANK);
  localparam logic [CW-1:0] VB_END = CW'(VB_CYC);

  logic [1:0]            rst_sync_q;
  logic                  rst_n;
  vps_state_e            state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] cval_q, cval_d;
  logic                  frame_start, eof_hs, hs, load;
  logic [PW-1:0]         pix;
  logic [PW-1:0]         tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
  logic                  busy_q, busy_d, fdone_q, fdone_d;
  logic [15:0]           fcnt_q, fcnt_d;

  assign hs = tvalid_q & m_axis_tready;

  // Reset synchronizer: assertion is immediate, release is aligned to clk.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};

  assign rst_n = rst_sync_q[1];

  // FSM state, coordinate counters, blank timer and per-frame mode latch.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      cval_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      cval_q  <= cval_d;
    end

  // Next-state and counter logic; x/y only move on a handshake.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    cval_d      = cval_q;
    frame_start = 1'b0;
    eof_hs      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DELAY;
          cnt_d   = '0;
        end
      end
      ST_DELAY: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else if (cnt_q == SD_END) begin
          state_d     = ST_ACTIVE;
          frame_start = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ACTIVE: begin
        if (hs) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d    = '0;
              eof_hs = 1'b1;
              if (VB_CYC == 0) begin
                if (start) frame_start = 1'b1;
                else       state_d     = ST_IDLE;
              end else begin
                state_d = ST_VBLANK;
                cnt_d   = CW'(1);
              end
            end else begin
              y_d = y_q + YW'(1);
              if (HBLANK != 0) begin
                state_d = ST_HBLANK;
                cnt_d   = CW'(1);
              end
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      ST_HBLANK: begin
        if (cnt_q == HB_END) state_d = ST_ACTIVE;
        else                 cnt_d   = cnt_q + CW'(1);
      end
      ST_VBLANK: begin
        if (cnt_q == VB_END) begin
          if (start) begin
            state_d     = ST_ACTIVE;
            frame_start = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (frame_start) begin
      mode_d = mode;
      cval_d = const_val;
    end
  end

  video_pattern_pixel #(
    .DATA_WIDTH(DATA_WIDTH),
    .CHANNELS  (CHANNELS),
    .XW        (XW),
    .YW        (YW)
  ) u_pixel (
    .x_i        (x_d),
    .y_i        (y_d),
    .mode_i     (mode_d),
    .const_val_i(cval_d),
    .pixel_o    (pix)
  );

  // Output next values: load a new beat only when the register is empty or being drained.
  always_comb begin
    load     = (state_d == ST_ACTIVE) && (!tvalid_q || m_axis_tready);
    tvalid_d = (state_d == ST_ACTIVE);
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    if (load) begin
      tdata_d = pix;
      tuser_d = (x_d == '0) && (y_d == '0);
      tlast_d = (x_d == X_LAST);
    end else if (state_d != ST_ACTIVE) begin
      tuser_d = 1'b0;
      tlast_d = 1'b0;
    end
    busy_d  = (state_d != ST_IDLE);
    fdone_d = eof_hs;
    fcnt_d  = fcnt_q + 16'(eof_hs);
  end

  // Registered AXI outputs and status.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      fdone_q  <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      fdone_q  <= fdone_d;
      fcnt_q   <= fcnt_d;
    end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign frame_done    = fdone_q;
  assign frame_cnt     = fcnt_q;

endmodule

// File: tb/tb_video_pattern_src.sv
// Bench for video_pattern_src: scoreboard of expected beats per frame, plus a wide-line
// instance for ramp wrap and frame counter wrap.
module tb_video_pattern_src;

  localparam int DW = 8;
  localparam int CH = 3;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int HB = 2;
  localparam int VB = 1;
  localparam int SD = 3;
  localparam int W2 = 300;
  localparam int H2 = 2;

  typedef struct packed {
    logic [DW*CH-1:0] data;
    logic             user;
    logic             last;
    logic             eof;
  } beat_t;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic             tready = 1'b1;
  logic [1:0]       mode = 2'd0;
  logic [DW-1:0]    cval = '0;
  logic [DW*CH-1:0] tdata;
  logic             tvalid, tuser, tlast, busy, frame_done;
  logic [15:0]      frame_cnt;

  logic             start2 = 1'b0;
  logic [DW-1:0]    tdata2;
  logic             tvalid2, tuser2, tlast2, busy2, fdone2;
  logic [15:0]      fcnt2;

  beat_t       sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          beats = 0;
  int          idle_run = 0;
  bit          gap_en = 0, after_tlast = 0, after_eof = 0, prev_eof = 0, rnd_en = 0;
  logic [15:0] fc_exp = '0;

  video_pattern_src #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .IMG_WIDTH(W), .IMG_HEIGHT(H),
    .HBLANK(HB), .VBLANK(VB), .START_DELAY(SD)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode), .const_val(cval),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tuser(tuser), .m_axis_tlast(tlast), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  video_pattern_src #(
    .DATA_WIDTH(DW), .CHANNELS(1), .IMG_WIDTH(W2), .IMG_HEIGHT(H2),
    .HBLANK(0), .VBLANK(0), .START_DELAY(0)
  ) dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .mode(2'd1), .const_val(8'h00),
    .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(1'b1),
    .m_axis_tuser(tuser2), .m_axis_tlast(tlast2), .busy(busy2),
    .frame_done(fdone2), .frame_cnt(fcnt2)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW*CH-1:0] model_px(input int x, input int y, input int m,
                                                input logic [DW-1:0] cv);
    logic [31:0]      xv, yv;
    logic [DW-1:0]    p;
    logic [DW*CH-1:0] r;
    xv = x;
    yv = y;
    case (m)
      0:       p = cv;
      1:       p = xv[DW-1:0];
      2:       p = yv[DW-1:0];
      default: p = (xv[3] ^ yv[3]) ? '1 : '0;
    endcase
    r = '0;
    for (int c = 0; c < CH; c++) r[c*DW +: DW] = p + DW'(c);
    return r;
  endfunction

  task automatic push_frame(input int m, input logic [DW-1:0] cv);
    beat_t e;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        e.data = model_px(x, y, m, cv);
        e.user = (x == 0) && (y == 0);
        e.last = (x == W - 1);
        e.eof  = (x == W - 1) && (y == H - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_beats(input int tgt, input string tag);
    int n = 0;
    while (beats < tgt && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (beats < tgt) chk({tag, "_timeout"}, 64'(beats), 64'(tgt));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy || sb.size() != 0) chk({tag, "_idle_timeout"}, 64'(sb.size()), 64'(0));
  endtask

  // Backpressure driver: random or always-ready, changed just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor and scoreboard compare.
  always @(negedge clk) begin
    beat_t e;
    if (resetn) begin
      if (frame_done || prev_eof) begin
        chk("frame_done", 64'(frame_done), 64'(prev_eof));
        if (frame_done) chk("frame_cnt", 64'(frame_cnt), 64'(fc_exp));
      end
      prev_eof = 0;
      if (!tvalid) begin
        idle_run++;
      end else begin
        if (gap_en && after_tlast)
          chk("blank_gap", 64'(idle_run), 64'(after_eof ? VB * (W + HB) : HB));
        after_tlast = 0;
        idle_run    = 0;
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'(1), 64'(0));
        end else if (tready) begin
          e = sb.pop_front();
          chk("beat", 64'({tdata, tuser, tlast}), 64'({e.data, e.user, e.last}));
          beats++;
          after_tlast = e.last;
          after_eof   = e.eof;
          if (e.eof) begin
            prev_eof = 1;
            fc_exp   = fc_exp + 16'd1;
          end
        end else begin
          chk("stall_hold", 64'({tdata, tuser, tlast}), 64'({sb[0].data, sb[0].user, sb[0].last}));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, n, k;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 64'(tvalid), 64'(0));
    chk("rst_tuser", 64'(tuser), 64'(0));
    chk("rst_tlast", 64'(tlast), 64'(0));
    chk("rst_tdata", 64'(tdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_fdone", 64'(frame_done), 64'(0));
    chk("rst_fcnt", 64'(frame_cnt), 64'(0));
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // Horizontal ramp, two back-to-back frames, start dropped at beat 10 of frame 2
    mode = 2'd1;
    push_frame(1, 8'h00);
    push_frame(1, 8'h00);
    gap_en = 1;
    start  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tvalid && n < 20);
    chk("start_latency", 64'(n - 1), 64'(SD + 1));
    wait_beats(W * H + 10, "t1_frame2");
    start = 1'b0;
    wait_idle("t1");
    gap_en = 0;
    chk("t1_beats", 64'(beats), 64'(2 * W * H));
    chk("t1_fcnt", 64'(frame_cnt), 64'(2));
    chk("t1_busy", 64'(busy), 64'(0));

    // Vertical ramp under random backpressure
    b0   = beats;
    mode = 2'd2;
    push_frame(2, 8'h00);
    rnd_en = 1;
    start  = 1'b1;
    wait_beats(b0 + 1, "t2_first");
    start = 1'b0;
    wait_idle("t2");
    rnd_en = 0;
    chk("t2_beats", 64'(beats - b0), 64'(W * H));

    // Mode change mid-frame takes effect only at the next frame
    b0   = beats;
    mode = 2'd0;
    cval = 8'h5A;
    push_frame(0, 8'h5A);
    start = 1'b1;
    wait_beats(b0 + 10, "t3_mid");
    mode = 2'd3;
    cval = 8'h11;
    push_frame(3, 8'h11);
    wait_beats(b0 + W * H + 1, "t3_next");
    start = 1'b0;
    wait_idle("t3");
    chk("t3_beats", 64'(beats - b0), 64'(2 * W * H));
    chk("t3_fcnt", 64'(frame_cnt), 64'(5));

    // Asynchronous reset mid-frame
    b0   = beats;
    mode = 2'd1;
    push_frame(1, 8'h00);
    start = 1'b1;
    wait_beats(b0 + 5, "t5_mid");
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_tvalid", 64'(tvalid), 64'(0));
    chk("t5_tuser", 64'(tuser), 64'(0));
    chk("t5_tlast", 64'(tlast), 64'(0));
    chk("t5_fcnt", 64'(frame_cnt), 64'(0));
    sb.delete();
    prev_eof    = 0;
    after_tlast = 0;
    idle_run    = 0;
    fc_exp      = '0;
    start       = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_idle_busy", 64'(busy), 64'(0));
    b0 = beats;
    push_frame(1, 8'h00);
    start = 1'b1;
    wait_beats(b0 + 1, "t5_restart");
    start = 1'b0;
    wait_idle("t5");
    chk("t5_beats", 64'(beats - b0), 64'(W * H));
    chk("t5_fcnt_after", 64'(frame_cnt), 64'(1));

    // Wide line: ramp wraps at x=256, frame counter wraps 0xFFFF -> 0
    force dut2.fcnt_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut2.fcnt_q;
    start2 = 1'b1;
    k = 0;
    n = 0;
    while (k < W2 * H2 && n < 3000) begin
      @(negedge clk);
      n++;
      if (tvalid2) begin
        chk("t6_px", 64'(tdata2), 64'((k % W2) % 256));
        chk("t6_user", 64'(tuser2), 64'(k == 0));
        chk("t6_last", 64'(tlast2), 64'((k % W2) == W2 - 1));
        k++;
        if (k == 1) start2 = 1'b0;
      end
    end
    chk("t6_beats", 64'(k), 64'(W2 * H2));
    @(negedge clk);
    chk("t6_fdone", 64'(fdone2), 64'(1));
    chk("t6_fcnt_wrap", 64'(fcnt2), 64'(0));
    chk("t6_busy", 64'(busy2), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
